// File: rtl/if_id_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface if_id_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/if_id_stage.sv
// MIPS instruction fetch + IF/ID register with delay-slot aware redirects and flush-drop.
// Optional IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt performance counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    if_id_stage_if.master     imem,
    input  logic [2:0]        npc_mux_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] cp0_target,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_instr,
    output logic              id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_DS = 2'd1,
        DROP    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              hold_vld_q, hold_vld_d;
    logic [31:0]       hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

    logic              req_o;
    logic [ADDR_W-1:0] addr_o;
    logic              flush_any;
    logic              done;
    logic              redir;
    logic              deliver;
    logic [ADDR_W-1:0] redir_tgt;

    assign flush_any = flush | (npc_mux_sel == 3'b100);
    assign done      = req_o & imem.imem_ready;

    // Redirects only come from a real branch/jump in ID; WAIT_DS/DROP never see one.
    assign redir = id_valid_q & ~stall & (state_q == RUN)
                 & ((npc_mux_sel == 3'b001) | (npc_mux_sel == 3'b010) | (npc_mux_sel == 3'b011));

    // A word enters ID either from the skid register or straight off the bus.
    assign deliver = ~flush_any & ~stall & (state_q != DROP) & (hold_vld_q | done);

    always_comb begin
        case (npc_mux_sel)
            3'b010:  redir_tgt = jump_target;
            3'b011:  redir_tgt = jr_target;
            default: redir_tgt = branch_target;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_any) begin
            state_d = (req_o & ~imem.imem_ready) ? DROP : RUN;
        end else begin
            case (state_q)
                RUN:     if (redir & ~deliver) state_d = WAIT_DS;
                WAIT_DS: if (deliver)          state_d = RUN;
                DROP:    if (done)             state_d = RUN;
                default:                       state_d = RUN;
            endcase
        end
    end

    // DROP keeps presenting the abandoned address until imem answers it.
    always_comb begin
        req_o  = run_q & ~hold_vld_q;
        addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
    end

    assign imem.imem_req  = req_o;
    assign imem.imem_addr = addr_o;

    always_comb begin
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        id_valid_d  = id_valid_q;
        tgt_d       = tgt_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        drop_addr_d = drop_addr_q;
        if (flush_any) begin
            pc_d        = cp0_target;
            id_valid_d  = 1'b0;
            hold_vld_d  = 1'b0;
            tgt_d       = '0;
            drop_addr_d = addr_o;
        end else if (!stall) begin
            id_valid_d = deliver;
            if (deliver) begin
                id_instr_d = hold_vld_q ? hold_data_q : imem.imem_rdata;
                id_pc_d    = pc_q;
                hold_vld_d = 1'b0;
                if (state_q == WAIT_DS) begin
                    pc_d = tgt_q;
                end else if (redir) begin
                    pc_d = redir_tgt;
                end else begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end else if (redir) begin
                tgt_d = redir_tgt;
            end
        end else if (done && (state_q != DROP)) begin
            // pc stays on the held word's address so it advances only when the word reaches ID
            hold_vld_d  = 1'b1;
            hold_data_d = imem.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            pc_q       <= RESET_PC[ADDR_W-1:0];
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
            tgt_q      <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            tgt_q      <= tgt_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        drop_addr_q <= drop_addr_d;
    end

    assign pc       = pc_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, deliver};
        bubble_cnt_d = bubble_cnt_q + {31'd0, ~stall & ~id_valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus a randomized run against a queue-based reference model.
module tb_if_id_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  npc_mux_sel;
    logic [31:0] branch_target, jump_target, jr_target, cp0_target;
    logic        stall, flush;
    logic [31:0] pc, id_pc, id_instr;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    if_id_stage_if #(.ADDR_W(32)) imem_bus ();

    if_id_stage #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .npc_mux_sel  (npc_mux_sel),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .cp0_target   (cp0_target),
        .stall        (stall),
        .flush        (flush),
        .pc           (pc),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_valid     (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch-stage state described as queues and flags
    bit          m_started;
    logic [31:0] m_pc, m_idpc, m_idins, m_drop_addr;
    bit          m_idv, m_drop;
    logic [31:0] m_pend[$];
    logic [31:0] m_hold[$];
`ifdef IF_PERF_CNT_EN
    logic [31:0] m_fetch, m_bubble;
`endif

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_started = 0; m_pc = RST_PC; m_idv = 0; m_idpc = 0; m_idins = 0;
        m_drop = 0; m_drop_addr = 0;
        m_pend.delete(); m_hold.delete();
`ifdef IF_PERF_CNT_EN
        m_fetch = 0; m_bubble = 0;
`endif
    endtask

    task automatic model_step();
        bit req, done, got, redir;
        logic [31:0] addr, word, tgt;
        req   = m_started && (m_hold.size() == 0);
        addr  = m_drop ? m_drop_addr : m_pc;
        done  = req && imem_bus.imem_ready;
        tgt   = (npc_mux_sel == 3'b010) ? jump_target :
                (npc_mux_sel == 3'b011) ? jr_target : branch_target;
        redir = m_idv && !stall && (npc_mux_sel inside {3'b001, 3'b010, 3'b011})
              && !m_drop && (m_pend.size() == 0);
        if (flush || npc_mux_sel == 3'b100) begin
            m_drop = req && !imem_bus.imem_ready;
            m_drop_addr = addr;
            m_pc = cp0_target; m_idv = 0;
            m_hold.delete(); m_pend.delete();
        end else if (m_drop) begin
            if (done) m_drop = 0;
            if (!stall) m_idv = 0;
        end else if (stall) begin
            if (done) m_hold.push_back(imem_bus.imem_rdata);
        end else begin
            got = done || (m_hold.size() != 0);
            if (m_hold.size() != 0) word = m_hold.pop_front();
            else word = imem_bus.imem_rdata;
            if (got) begin
                m_idv = 1; m_idpc = m_pc; m_idins = word;
`ifdef IF_PERF_CNT_EN
                m_fetch = m_fetch + 1;
`endif
                if (m_pend.size() != 0) m_pc = m_pend.pop_front();
                else if (redir) m_pc = tgt;
                else m_pc = m_pc + 32'd4;
            end else begin
                m_idv = 0;
                if (redir) m_pend.push_back(tgt);
            end
        end
`ifdef IF_PERF_CNT_EN
        if (!stall && !m_idv) m_bubble = m_bubble + 1;
`endif
        m_started = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        imem_bus.imem_rdata = word_at(imem_bus.imem_addr);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; npc_mux_sel = 3'b000;
        branch_target = 0; jump_target = 0; jr_target = 0; cp0_target = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_inputs();
        imem_bus.imem_ready = 0; imem_bus.imem_rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        imem_bus.imem_ready = 1;
        imem_bus.imem_rdata = word_at(imem_bus.imem_addr);
    endtask

    // which=0: wait for address a in ID; which=1: wait for address a on the fetch bus
    task automatic run_until(input bit which, input logic [31:0] a, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!which && id_valid === 1'b1 && id_pc === a) begin ok = 1; break; end
            if (which && imem_bus.imem_addr === a) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        imem_bus.imem_ready = 1; imem_bus.imem_rdata = 0;
        model_reset();
        @(posedge clk); #1;
        n_tests++;
        if (pc !== RST_PC || id_pc !== 0 || id_instr !== 0 || id_valid !== 0 || imem_bus.imem_req !== 0) begin
            n_fail++;
            $display("FAIL reset_values: pc=%h id_pc=%h id_instr=%h v=%b req=%b want pc=%h rest 0",
                     pc, id_pc, id_instr, id_valid, imem_bus.imem_req, RST_PC);
        end
        #2 rst_n = 1;
        tick();
        n_tests++;
        if (imem_bus.imem_req !== 1 || imem_bus.imem_addr !== 32'h0040_0000 || id_valid !== 0) begin
            n_fail++;
            $display("FAIL seq_cycle1: req=%b addr=%h v=%b want 1 00400000 0",
                     imem_bus.imem_req, imem_bus.imem_addr, id_valid);
        end
        tick();
        n_tests++;
        if (imem_bus.imem_addr !== 32'h0040_0004 || id_valid !== 1 || id_pc !== 32'h0040_0000
            || id_instr !== word_at(32'h0040_0000)) begin
            n_fail++;
            $display("FAIL seq_cycle2: addr=%h v=%b id_pc=%h ins=%h want 00400004 1 00400000 %h",
                     imem_bus.imem_addr, id_valid, id_pc, id_instr, word_at(32'h0040_0000));
        end
        tick();
        n_tests++;
        if (imem_bus.imem_addr !== 32'h0040_0008 || id_pc !== 32'h0040_0004) begin
            n_fail++;
            $display("FAIL seq_cycle3: addr=%h id_pc=%h want 00400008 00400004", imem_bus.imem_addr, id_pc);
        end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        run_until(0, 32'h0040_0010, ok);
        n_tests++;
        if (!ok || pc !== 32'h0040_0014) begin
            n_fail++;
            $display("FAIL br_reach: ok=%b pc=%h want 1 00400014", ok, pc);
        end
        npc_mux_sel = 3'b001; branch_target = 32'h0040_0100;
        tick();
        npc_mux_sel = 3'b000;
        n_tests++;
        if (id_valid !== 1 || id_pc !== 32'h0040_0014 || id_instr !== word_at(32'h0040_0014)
            || imem_bus.imem_addr !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL br_delay_slot: v=%b id_pc=%h ins=%h addr=%h want 1 00400014 %h 00400100",
                     id_valid, id_pc, id_instr, imem_bus.imem_addr, word_at(32'h0040_0014));
        end
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL br_target: v=%b id_pc=%h want 1 00400100", id_valid, id_pc);
        end
    endtask

    task automatic test_branch_wait();
        bit ok;
        do_reset();
        run_until(0, 32'h0040_0010, ok);
        npc_mux_sel = 3'b001; branch_target = 32'h0040_0100;
        imem_bus.imem_ready = 0;
        tick();
        npc_mux_sel = 3'b000;
        n_tests++;
        if (!ok || id_valid !== 0 || imem_bus.imem_addr !== 32'h0040_0014 || imem_bus.imem_req !== 1) begin
            n_fail++;
            $display("FAIL bw_enter: ok=%b v=%b addr=%h req=%b want 1 0 00400014 1",
                     ok, id_valid, imem_bus.imem_addr, imem_bus.imem_req);
        end
        repeat (2) begin
            tick();
            n_tests++;
            if (imem_bus.imem_addr !== 32'h0040_0014 || id_valid !== 0) begin
                n_fail++;
                $display("FAIL bw_hold_addr: addr=%h v=%b want 00400014 0", imem_bus.imem_addr, id_valid);
            end
        end
        imem_bus.imem_ready = 1;
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== 32'h0040_0014 || id_instr !== word_at(32'h0040_0014)
            || imem_bus.imem_addr !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL bw_delay_slot: v=%b id_pc=%h ins=%h addr=%h want 1 00400014 %h 00400100",
                     id_valid, id_pc, id_instr, imem_bus.imem_addr, word_at(32'h0040_0014));
        end
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL bw_target: v=%b id_pc=%h want 1 00400100", id_valid, id_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] p, ins;
        do_reset();
        repeat (5) tick();
        p = id_pc; ins = id_instr;
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (id_pc !== p || id_instr !== ins || id_valid !== 1 || imem_bus.imem_req !== 0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: id_pc=%h ins=%h v=%b req=%b want %h %h 1 0",
                         i, id_pc, id_instr, id_valid, imem_bus.imem_req, p, ins);
            end
        end
        stall = 0;
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== p + 4 || id_instr !== word_at(p + 4)
            || imem_bus.imem_req !== 1 || imem_bus.imem_addr !== p + 8) begin
            n_fail++;
            $display("FAIL stall_skid: v=%b id_pc=%h ins=%h req=%b addr=%h want 1 %h %h 1 %h",
                     id_valid, id_pc, id_instr, imem_bus.imem_req, imem_bus.imem_addr, p + 4, word_at(p + 4), p + 8);
        end
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== p + 8) begin
            n_fail++;
            $display("FAIL stall_next: v=%b id_pc=%h want 1 %h", id_valid, id_pc, p + 8);
        end
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        run_until(1, 32'h0040_0020, ok);
        imem_bus.imem_ready = 0; flush = 1; cp0_target = 32'h0040_0004;
        tick();
        flush = 0;
        n_tests++;
        if (!ok || id_valid !== 0 || imem_bus.imem_req !== 1 || imem_bus.imem_addr !== 32'h0040_0020
            || pc !== 32'h0040_0004) begin
            n_fail++;
            $display("FAIL flush_drop: ok=%b v=%b req=%b addr=%h pc=%h want 1 0 1 00400020 00400004",
                     ok, id_valid, imem_bus.imem_req, imem_bus.imem_addr, pc);
        end
        tick();
        n_tests++;
        if (imem_bus.imem_addr !== 32'h0040_0020 || id_valid !== 0) begin
            n_fail++;
            $display("FAIL flush_wait: addr=%h v=%b want 00400020 0", imem_bus.imem_addr, id_valid);
        end
        imem_bus.imem_ready = 1;
        tick();
        n_tests++;
        if (id_valid !== 0 || imem_bus.imem_addr !== 32'h0040_0004) begin
            n_fail++;
            $display("FAIL flush_discard: v=%b addr=%h want 0 00400004", id_valid, imem_bus.imem_addr);
        end
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== 32'h0040_0004 || id_instr !== word_at(32'h0040_0004)) begin
            n_fail++;
            $display("FAIL flush_resume: v=%b id_pc=%h ins=%h want 1 00400004 %h",
                     id_valid, id_pc, id_instr, word_at(32'h0040_0004));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (3) tick();
        npc_mux_sel = 3'b100; cp0_target = 32'hFFFF_FFFC;
        tick();
        npc_mux_sel = 3'b000;
        n_tests++;
        if (imem_bus.imem_addr !== 32'hFFFF_FFFC || id_valid !== 0) begin
            n_fail++;
            $display("FAIL wrap_vec: addr=%h v=%b want fffffffc 0", imem_bus.imem_addr, id_valid);
        end
        tick();
        n_tests++;
        if (imem_bus.imem_addr !== 32'h0000_0000 || id_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_pc: addr=%h id_pc=%h want 00000000 fffffffc", imem_bus.imem_addr, id_pc);
        end
        flush = 1; cp0_target = 32'h0000_0102;
        tick();
        flush = 0;
        tick();
        n_tests++;
        if (imem_bus.imem_addr !== 32'h0000_0106 || id_pc !== 32'h0000_0102) begin
            n_fail++;
            $display("FAIL low_bits: addr=%h id_pc=%h want 00000106 00000102", imem_bus.imem_addr, id_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        run_until(0, 32'h0040_0010, ok);
        npc_mux_sel = 3'b001; branch_target = 32'h0040_0100;
        imem_bus.imem_ready = 0;
        tick();
        npc_mux_sel = 3'b000;
        #2 rst_n = 0;
        #1;
        model_reset();
        n_tests++;
        if (!ok || pc !== RST_PC || id_pc !== 0 || id_instr !== 0 || id_valid !== 0 || imem_bus.imem_req !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: ok=%b pc=%h id_pc=%h ins=%h v=%b req=%b want 1 %h 0 0 0 0",
                     ok, pc, id_pc, id_instr, id_valid, imem_bus.imem_req, RST_PC);
        end
        @(posedge clk);
        #2 rst_n = 1;
        imem_bus.imem_ready = 1;
        tick();
        n_tests++;
        if (imem_bus.imem_req !== 1 || imem_bus.imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL rst_mid_fetch: req=%b addr=%h want 1 %h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
        end
        tick();
        n_tests++;
        if (id_valid !== 1 || id_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL rst_mid_id: v=%b id_pc=%h want 1 %h", id_valid, id_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        int unsigned r;
        bit          e_req;
        logic [31:0] e_addr;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_bus.imem_ready = ($urandom_range(3) != 0);
            stall = ($urandom_range(5) == 0);
            flush = ($urandom_range(60) == 0);
            r = $urandom_range(15);
            npc_mux_sel = (r < 9) ? 3'b000 : (r < 11) ? 3'b001 : (r < 13) ? 3'b010 :
                          (r < 15) ? 3'b011 : (($urandom_range(3) == 0) ? 3'b100 : 3'b000);
            branch_target = $urandom;
            jump_target   = $urandom;
            jr_target     = $urandom;
            cp0_target    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            imem_bus.imem_rdata = $urandom;
            tick();
            e_req  = m_started && (m_hold.size() == 0);
            e_addr = m_drop ? m_drop_addr : m_pc;
            n_tests++;
            if (imem_bus.imem_req !== e_req || imem_bus.imem_addr !== e_addr || pc !== m_pc
                || id_valid !== m_idv || (m_idv && (id_pc !== m_idpc || id_instr !== m_idins))) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: req/addr/pc/v/id_pc/ins got %b %h %h %b %h %h want %b %h %h %b %h %h",
                         cyc, imem_bus.imem_req, imem_bus.imem_addr, pc, id_valid, id_pc, id_instr,
                         e_req, e_addr, m_pc, m_idv, m_idpc, m_idins);
            end
`ifdef IF_PERF_CNT_EN
            n_tests++;
            if (fetch_cnt !== m_fetch || bubble_cnt !== m_bubble) begin
                n_fail++;
                $display("FAIL rand_cnt%0d: fetch/bubble got %0d %0d want %0d %0d",
                         cyc, fetch_cnt, bubble_cnt, m_fetch, m_bubble);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branch();
        test_branch_wait();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the ID-stage control unit.
- Owns the PC and runs the instruction-memory request/ready handshake.
- Consumes npc_mux_sel, stall and flush from the control unit; presents id_instr/id_pc/id_valid to it.
- Honours the MIPS branch delay slot, including when the delay-slot fetch is still outstanding at redirect time.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
ADDR_W, 32, PC / imem address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
npc_mux_sel  in  3  next-PC select from control unit: 000 seq, 001 branch, 010 j/jal, 011 jr, 100 cp0 vector.
branch_target  in  32  PC-relative branch target computed in ID.
jump_target  in  32  j/jal target computed in ID.
jr_target  in  32  rs value (bypassed) for jr.
cp0_target  in  32  exception vector or EPC (eret) from CP0.
stall  in  1  ID load-use / mfc0 hold.
flush  in  1  exception or eret flush.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address (= pc).
imem_rdata  in  32  fetched word, valid when imem_ready.
imem_ready  in  1  fetch complete this cycle.
pc  out  32  current fetch PC.
id_pc  out  32  PC of instruction in ID.
id_instr  out  32  instruction in ID.
id_valid  out  1  ID slot holds a real instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, id_pc=0, id_instr=0, id_valid=0, imem_req=0, state=RUN, redirect buffer cleared. imem_req goes to 1 in the first cycle after reset release.
- Handshake: imem_req stays high with imem_addr stable until imem_ready. One transaction outstanding at most. A transaction completes on any cycle where imem_req=1 and imem_ready=1; zero-wait (ready in the same cycle) is legal.
- Capture, on completion with stall=0, flush=0, state != DROP:
  - id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
  - pc <= next_pc.
- No completion and stall=0: id_valid <= 0 (bubble).
- stall=1: IF/ID holds, pc holds, redirect is ignored. The completed word is held in a 1-entry skid register (hold_vld) and delivered when stall drops; no new request is issued while hold_vld=1.
- next_pc: if a redirect is pending, the pending target, else pc+4.
- Redirect is accepted when id_valid=1, stall=0 and npc_mux_sel is 001, 010 or 011. The accepted target is the selected input.
- Delay slot: the fetch at pc (= id_pc+4) is the delay slot and is always kept.
  - If it completes in the same cycle as the redirect, pc <= target directly.
  - Otherwise the target is latched and state=WAIT_DS. On completion, pc <= target and state returns to RUN.
- flush=1, or npc_mux_sel=100 (highest priority over everything including stall):
  - id_valid <= 0, hold_vld <= 0, pending redirect cleared, pc <= cp0_target.
  - If a transaction is outstanding and not completing this cycle, state=DROP. DROP keeps imem_req=1 at the old address until imem_ready, discards the data, then returns to RUN and fetches cp0_target.
- States: RUN, WAIT_DS, DROP. Transitions:
  - RUN -> WAIT_DS on a deferred redirect.
  - RUN or WAIT_DS -> DROP on a flush with an outstanding fetch.
  - WAIT_DS -> RUN on completion.
  - DROP -> RUN on completion.
- pc arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Low two bits are carried unchanged.
- A second redirect while in WAIT_DS is impossible (the delay slot is not in ID yet). A flush overrides it.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds output ports fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and wrapping.
  - fetch_cnt increments on each instruction captured into ID.
  - bubble_cnt increments on each cycle with stall=0 and id_valid next=0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, imem_ready always 1 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; id_valid=1 from cycle 2.
- beq in ID at 0x00400010, sel=001, target 0x00400100, ready=1 -> delay slot 0x00400014 enters ID, next fetch 0x00400100.
- Same as the previous case but imem_ready delayed 3 cycles on 0x00400014 -> state WAIT_DS, addr stays 0x00400014, then 0x00400100; delay slot still delivered.
- stall=1 for 2 cycles with ready=1 -> id_instr/id_pc unchanged, the skid word is delivered after release, no fetch lost or duplicated.
- flush with cp0_target 0x00400004 while the fetch of 0x00400020 is outstanding (ready late 2 cycles) -> id_valid=0, DROP, data of 0x00400020 discarded, next request 0x00400004.
- rst_n asserted mid-WAIT_DS -> all outputs at reset values immediately, first fetch at RESET_PC.
